hop_seq_ctrl: RTL and testbench

// Parametrised hop-sequence controller for the tag-chip multi-tone TX path.

---
 rtl/hop_seq_ctrl_pkg.sv | 14 +
 rtl/hop_code_ram.sv | 25 ++
 rtl/hop_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_hop_seq_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hop_seq_ctrl_pkg.sv
// hop_seq_ctrl_pkg: state encoding and default phase constants for the hop-sequence controller
package hop_seq_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOC_SYNCH = 3'd1,
    HOP_SYNCH = 3'd2,
    HOP_TX    = 3'd3
  } state_t;
  localparam int DEF_START_PH_INC = -4194304;
  localparam int DEF_DPH_INC = 131072;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/hop_code_ram.sv
// hop_code_ram: simple dual-port hop-code table, one write port and one registered read port
//   clk, reset            : clock, sync active-high reset (clears only the read register)
//   wr_en/wr_addr/wr_data : table write
//   rd_en/rd_addr/rd_data : read issued on rd_en, data valid next cycle and held until the next read
module hop_code_ram #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_addr] <= wr_data;
  // Same-address write and read in one cycle returns the old entry.
  always_ff @(posedge clk)
    if (reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
endmodule

// File: rtl/hop_seq_ctrl.sv
// hop_seq_ctrl: hop-sequence controller, one local sync then N hops of hop-sync -> hop-TX
//   in : clk, reset, start, abort, continuous, num_hops, code_wr_en/addr/data, hop_done
//   out: state_o, sync_active, tx_valid, hop_rst, hop_n, hop_phase_inc, hop_code,
//        busy, seq_done, hop_timeout
module hop_seq_ctrl
  import hop_seq_ctrl_pkg::*;
#(
  parameter int PHASE_WIDTH = 24,
  parameter int CODE_WIDTH = 32,
  parameter int HOP_IDX_WIDTH = 6,
  parameter int LOC_SYNC_N = 16384,
  parameter int HOP_SYNC_N = 16384,
  parameter int HOP_TIMEOUT_N = 1048576,
  parameter int HOP_START_PH_INC = DEF_START_PH_INC,
  parameter int HOP_DPH_INC = DEF_DPH_INC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     continuous,
  input  logic [HOP_IDX_WIDTH-1:0] num_hops,
  input  logic                     code_wr_en,
  input  logic [HOP_IDX_WIDTH-1:0] code_wr_addr,
  input  logic [CODE_WIDTH-1:0]    code_wr_data,
  input  logic                     hop_done,
  output logic [2:0]               state_o,
  output logic                     sync_active,
  output logic                     tx_valid,
  output logic                     hop_rst,
  output logic [HOP_IDX_WIDTH-1:0] hop_n,
  output logic [PHASE_WIDTH-1:0]   hop_phase_inc,
  output logic [CODE_WIDTH-1:0]    hop_code,
  output logic                     busy,
  output logic                     seq_done,
  output logic                     hop_timeout
);
  localparam int CNT_W = $clog2(max3(LOC_SYNC_N, HOP_SYNC_N, HOP_TIMEOUT_N) + 1);
  localparam logic [CNT_W-1:0] LOC_LAST = CNT_W'(LOC_SYNC_N - 1);
  localparam logic [CNT_W-1:0] HOP_LAST = CNT_W'(HOP_SYNC_N - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(HOP_TIMEOUT_N - 1);
  localparam logic [PHASE_WIDTH-1:0] PH0 = PHASE_WIDTH'(HOP_START_PH_INC);
  localparam logic [PHASE_WIDTH-1:0] DPH = PHASE_WIDTH'(HOP_DPH_INC);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [HOP_IDX_WIDTH-1:0] hop_d, nh_q, nh_d;
  logic [PHASE_WIDTH-1:0] ph_d;
  logic done_d, to_d, load, to_hit, hop_end;
  // cnt counts down in the sync states and up (timeout) in HOP_TX.
  assign to_hit = (HOP_TIMEOUT_N != 0) && cnt == TO_LAST;
  assign hop_end = hop_done || to_hit;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    hop_d = hop_n;
    ph_d = hop_phase_inc;
    nh_d = nh_q;
    done_d = 1'b0;
    to_d = 1'b0;
    load = 1'b0;
    case (state)
      IDLE: load = start;
      LOC_SYNCH: begin
        state_n = cnt == '0 ? HOP_SYNCH : LOC_SYNCH;
        cnt_n = cnt == '0 ? HOP_LAST : cnt - 1'b1;
      end
      HOP_SYNCH: begin
        state_n = cnt == '0 ? HOP_TX : HOP_SYNCH;
        cnt_n = cnt == '0 ? '0 : cnt - 1'b1;
      end
      HOP_TX:
        if (hop_end) begin
          to_d = !hop_done;
          if (hop_n < nh_q) begin
            hop_d = hop_n + 1'b1;
            ph_d = hop_phase_inc + DPH;
            state_n = HOP_SYNCH;
            cnt_n = HOP_LAST;
          end else begin
            done_d = 1'b1;
            state_n = IDLE;
            load = continuous;
          end
        end else cnt_n = cnt + 1'b1;
      default: state_n = IDLE;
    endcase
    if (load) begin
      state_n = LOC_SYNCH;
      cnt_n = LOC_LAST;
      hop_d = '0;
      ph_d = PH0;
      nh_d = num_hops;
    end
    // Phase always tracks hop_n, so clearing hop_n also reloads the phase.
    if (abort) begin
      state_n = IDLE;
      hop_d = '0;
      ph_d = PH0;
      done_d = 1'b0;
      to_d = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      hop_n <= '0;
      hop_phase_inc <= PH0;
      nh_q <= '0;
      seq_done <= 1'b0;
      hop_timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      hop_n <= hop_d;
      hop_phase_inc <= ph_d;
      nh_q <= nh_d;
      seq_done <= done_d;
      hop_timeout <= to_d;
    end
  assign state_o = state;
  assign sync_active = state == LOC_SYNCH || state == HOP_SYNCH;
  assign tx_valid = state == HOP_TX;
  assign busy = state != IDLE;
  assign hop_rst = state == HOP_SYNCH && cnt == HOP_LAST;
  hop_code_ram #(.AW(HOP_IDX_WIDTH), .DW(CODE_WIDTH)) u_ram (
    .clk(clk),
    .reset(reset),
    .wr_en(code_wr_en),
    .wr_addr(code_wr_addr),
    .wr_data(code_wr_data),
    .rd_en(hop_rst),
    .rd_addr(hop_n),
    .rd_data(hop_code)
  );
endmodule

// File: tb/tb_hop_seq_ctrl.sv
// tb_hop_seq_ctrl: directed and random checks of hop_seq_ctrl against a behavioural model
module tb_hop_seq_ctrl;
  import hop_seq_ctrl_pkg::*;
  localparam int PW = 24, CW = 32, IW = 6;
  localparam int LOC_N = 8, HS_N = 4, TO_N = 16;
  localparam int START_PH = -4194304, DPH = 131072;
  logic clk = 0, reset = 1, start = 0, abort = 0, continuous = 0, code_wr_en = 0, hop_done = 0;
  logic [IW-1:0] num_hops = '0, code_wr_addr = '0;
  logic [CW-1:0] code_wr_data = '0;
  logic [2:0] state_o;
  logic sync_active, tx_valid, hop_rst, busy, seq_done, hop_timeout;
  logic [IW-1:0] hop_n;
  logic [PW-1:0] hop_phase_inc;
  logic [CW-1:0] hop_code;
  always #5 clk = ~clk;
  hop_seq_ctrl #(
    .PHASE_WIDTH(PW), .CODE_WIDTH(CW), .HOP_IDX_WIDTH(IW),
    .LOC_SYNC_N(LOC_N), .HOP_SYNC_N(HS_N), .HOP_TIMEOUT_N(TO_N),
    .HOP_START_PH_INC(START_PH), .HOP_DPH_INC(DPH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .continuous(continuous),
    .num_hops(num_hops), .code_wr_en(code_wr_en), .code_wr_addr(code_wr_addr),
    .code_wr_data(code_wr_data), .hop_done(hop_done), .state_o(state_o),
    .sync_active(sync_active), .tx_valid(tx_valid), .hop_rst(hop_rst), .hop_n(hop_n),
    .hop_phase_inc(hop_phase_inc), .hop_code(hop_code), .busy(busy),
    .seq_done(seq_done), .hop_timeout(hop_timeout)
  );
  int n_checks = 0, n_errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  state_t m_state = IDLE;
  int m_el = 0, m_hop = 0, m_nh = 0;
  logic [CW-1:0] m_tab [2**IW];
  logic [CW-1:0] m_code = '0;
  logic m_done = 0, m_to = 0;
  function automatic logic [PW-1:0] exp_ph(input int h);
    int v;
    v = START_PH + h * DPH;
    return PW'(v);
  endfunction
  task automatic m_restart();
    m_state = LOC_SYNCH;
    m_el = 0;
    m_hop = 0;
    m_nh = int'(num_hops);
  endtask
  task automatic model();
    m_done = 0;
    m_to = 0;
    if (!reset && m_state == HOP_SYNCH && m_el == 0) m_code = m_tab[m_hop];
    if (code_wr_en) m_tab[code_wr_addr] = code_wr_data;
    if (reset) begin
      m_state = IDLE; m_el = 0; m_hop = 0; m_code = '0;
    end else if (abort) begin
      m_state = IDLE; m_el = 0; m_hop = 0;
    end else
      case (m_state)
        IDLE: if (start) m_restart();
        LOC_SYNCH: if (m_el == LOC_N - 1) begin m_state = HOP_SYNCH; m_el = 0; end else m_el++;
        HOP_SYNCH: if (m_el == HS_N - 1) begin m_state = HOP_TX; m_el = 0; end else m_el++;
        HOP_TX:
          if (hop_done || m_el == TO_N - 1) begin
            m_to = !hop_done;
            if (m_hop < m_nh) begin
              m_hop++; m_state = HOP_SYNCH; m_el = 0;
            end else begin
              m_done = 1;
              if (continuous) m_restart();
              else m_state = IDLE;
            end
          end else m_el++;
        default: m_state = IDLE;
      endcase
  endtask
  task automatic step();
    @(posedge clk);
    model();
    #1;
    check("state", 32'(state_o), 32'(m_state));
    check("flags", {busy, sync_active, tx_valid, hop_rst, seq_done, hop_timeout},
          {m_state != IDLE, m_state == LOC_SYNCH || m_state == HOP_SYNCH, m_state == HOP_TX,
           m_state == HOP_SYNCH && m_el == 0, m_done, m_to});
    check("hop_n", 32'(hop_n), 32'(m_hop));
    check("phase", 32'(hop_phase_inc), 32'(exp_ph(m_hop)));
    check("code", hop_code, m_code);
  endtask
  initial begin
    int nd, nr, nto, ntx;
    bit fin;
    logic [PW-1:0] ph_q[$];
    logic [PW-1:0] ph_exp [3];
    ph_exp = '{24'hC00000, 24'hC20000, 24'hC40000};
    reset = 1;
    for (int i = 0; i < 2**IW; i++) begin
      code_wr_en = 1;
      code_wr_addr = IW'(i);
      code_wr_data = i == 1 ? 32'hDEADBEEF : $urandom;
      step();
    end
    code_wr_en = 0;
    check("rst_state", 32'(state_o), 0);
    check("rst_phase", 32'(hop_phase_inc), 32'h00C00000);
    check("rst_outs", {busy, tx_valid, sync_active, hop_rst, seq_done, hop_timeout, hop_n}, 0);
    check("rst_code", hop_code, 0);
    reset = 0;
    step();
    // one-shot, three hops, done 3 cycles into TX, stray start / hop_done ignored
    num_hops = 2; continuous = 0; start = 1;
    step();
    start = 0; nd = 0; nr = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      start = m_state == LOC_SYNCH && m_el == 3;
      hop_done = (m_state == HOP_TX && m_el == 2) || (m_state == HOP_SYNCH && m_el == 1);
      step();
      if (hop_rst) nr++;
      if (seq_done) begin nd++; fin = 1; end
      if (tx_valid && m_el == 0) ph_q.push_back(hop_phase_inc);
      if (m_state == HOP_SYNCH && m_hop == 1 && m_el == 1) check("code_hop1", hop_code, 32'hDEADBEEF);
    end
    start = 0; hop_done = 0;
    check("seq1_end", 32'(fin), 1);
    check("seq1_done_cnt", nd, 1);
    check("seq1_rst_cnt", nr, 3);
    check("seq1_nph", ph_q.size(), 3);
    for (int k = 0; k < 3; k++)
      if (ph_q.size() > k) check("seq1_ph", 32'(ph_q[k]), 32'(ph_exp[k]));
    check("seq1_hop_last", 32'(hop_n), 2);
    check("seq1_idle", 32'(state_o), 0);
    step();
    check("seq1_one_pulse", 32'(seq_done), 0);
    // timeout on hop 0, hop_done on the final allowed cycle of hop 1
    num_hops = 1; start = 1;
    step();
    start = 0; nto = 0; ntx = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      hop_done = m_state == HOP_TX && m_hop == 1 && m_el == TO_N - 1;
      step();
      if (hop_timeout) nto++;
      if (tx_valid) ntx++;
      if (seq_done) fin = 1;
    end
    hop_done = 0;
    check("to_end", 32'(fin), 1);
    check("to_pulses", nto, 1);
    check("to_tx_cycles", ntx, 2 * TO_N);
    // continuous, single hop per pass
    continuous = 1; num_hops = 0; start = 1;
    step();
    start = 0; nd = 0; nr = 0;
    for (int i = 0; i < 500 && nd < 3; i++) begin
      hop_done = m_state == HOP_TX && m_el == 0;
      step();
      if (hop_rst) nr++;
      if (seq_done) nd++;
    end
    check("cont_done_cnt", nd, 3);
    check("cont_rst_cnt", nr, 3);
    check("cont_reloc", 32'(state_o), 32'(LOC_SYNCH));
    check("cont_phase", 32'(hop_phase_inc), 32'h00C00000);
    continuous = 0; fin = 0;
    for (int i = 0; i < 100 && !fin; i++) begin
      hop_done = m_state == HOP_TX && m_el == 0;
      step();
      fin = state_o == 3'd0;
    end
    hop_done = 0;
    check("cont_stop", 32'(fin), 1);
    // abort during hop-1 sync
    num_hops = 1; start = 1;
    step();
    start = 0; fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      hop_done = m_state == HOP_TX && m_el == 0;
      fin = m_state == HOP_SYNCH && m_hop == 1 && m_el == 1;
      if (!fin) step();
    end
    hop_done = 0;
    check("abort_reach", 32'(fin), 1);
    abort = 1;
    step();
    abort = 0;
    check("abort_state", 32'(state_o), 0);
    check("abort_hop", 32'(hop_n), 0);
    check("abort_tx", {tx_valid, seq_done}, 0);
    step();
    check("abort_no_done", 32'(seq_done), 0);
    // reset during hop-1 TX
    num_hops = 2; start = 1;
    step();
    start = 0; fin = 0;
    for (int i = 0; i < 200 && !fin; i++) begin
      hop_done = m_state == HOP_TX && m_hop == 0 && m_el == 0;
      fin = m_state == HOP_TX && m_hop == 1 && m_el == 1;
      if (!fin) step();
    end
    hop_done = 0;
    check("reset_reach", 32'(fin), 1);
    reset = 1;
    step();
    reset = 0;
    check("reset_state", 32'(state_o), 0);
    check("reset_outs", {tx_valid, seq_done, hop_timeout, hop_n}, 0);
    step();
    check("reset_no_done", 32'(seq_done), 0);
    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      start = $urandom_range(0, 7) == 0;
      abort = $urandom_range(0, 79) == 0;
      hop_done = $urandom_range(0, 5) == 0;
      continuous = 1'($urandom_range(0, 1));
      num_hops = IW'($urandom_range(0, 3));
      code_wr_en = $urandom_range(0, 3) == 0;
      code_wr_addr = IW'($urandom_range(0, 3));
      code_wr_data = $urandom;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
